// File: rtl/motor_seq_pkg.sv
// Shared types and direction encodings for the motor drive sequencer.
// Direction pairs are packed as {dir1, dir2}.
package motor_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    RAMPDOWN,
    DEAD,
    ESTOP
  } chan_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  localparam logic [1:0] ENC_COAST = 2'b00;
  localparam logic [1:0] ENC_FWD   = 2'b10;
  localparam logic [1:0] ENC_REV   = 2'b01;
  localparam logic [1:0] ENC_BRAKE = 2'b11;

  function automatic logic [1:0] dir_enc(input logic dir);
    return (dir == DIR_REV) ? ENC_REV : ENC_FWD;
  endfunction

endpackage

// File: rtl/motor_channel_fsm.sv
// One motor channel: state machine, rate-limited duty ramp and
// dead-time counter between opposite drive directions.
module motor_channel_fsm
  import motor_seq_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int STEP       = 4,
  parameter int DEAD_TICKS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_i,
  input  logic              estop_i,
  input  logic              tgt_dir_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              dir1_o,
  output logic              dir2_o,
  output logic              busy_o
);

  localparam int AW = DUTY_W + 1;
  localparam int CW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_TICKS - 1);

  chan_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              cur_q, cur_d;
  logic [CW-1:0]     dead_q, dead_d;

  logic [AW-1:0] cur_a, tgt_a;
  logic [AW-1:0] toward_a, fall_a;
  logic [DUTY_W-1:0] toward, fall;

  function automatic logic [AW-1:0] lim(input logic [AW-1:0] d);
    return (d < STEP_A) ? d : STEP_A;
  endfunction

  always_comb begin
    cur_a = {1'b0, duty_q};
    tgt_a = {1'b0, tgt_duty_i};
    if (tgt_a > cur_a) begin
      toward_a = cur_a + lim(tgt_a - cur_a);
    end else begin
      toward_a = cur_a - lim(cur_a - tgt_a);
    end
    fall_a = cur_a - lim(cur_a);
    // clamp keeps duty inside the legal range even if the sum wraps
    toward = toward_a[DUTY_W] ? '1 : toward_a[DUTY_W-1:0];
    fall   = fall_a[DUTY_W] ? '0 : fall_a[DUTY_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      duty_q  <= '0;
      cur_q   <= DIR_FWD;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      cur_q   <= cur_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cur_d   = cur_q;
    dead_d  = dead_q;
    if (estop_i) begin
      state_d = ESTOP;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tgt_duty_i != '0) begin
            state_d = DRIVE;
            cur_d   = tgt_dir_i;
          end
        end
        DRIVE: begin
          if (tgt_dir_i != cur_q) begin
            if (tick_i) duty_d = fall;
            if (duty_d == '0) begin
              state_d = DEAD;
              dead_d  = '0;
            end else begin
              state_d = RAMPDOWN;
            end
          end else begin
            if (tick_i) duty_d = toward;
            if (tgt_duty_i == '0 && duty_d == '0) state_d = IDLE;
          end
        end
        RAMPDOWN: begin
          if (tick_i) duty_d = fall;
          if (duty_d == '0) begin
            state_d = DEAD;
            dead_d  = '0;
          end
        end
        DEAD: begin
          if (tick_i) begin
            if (dead_q == DEAD_LAST) begin
              dead_d = '0;
              if (tgt_duty_i != '0) begin
                state_d = DRIVE;
                cur_d   = tgt_dir_i;
              end else begin
                state_d = IDLE;
              end
            end else begin
              dead_d = dead_q + CW'(1);
            end
          end
        end
        ESTOP: begin
          state_d = DEAD;
          dead_d  = '0;
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  logic [1:0] enc;

  always_comb begin
    enc = ENC_COAST;
    unique case (state_q)
      DRIVE, RAMPDOWN: enc = dir_enc(cur_q);
      ESTOP:           enc = ENC_BRAKE;
      default:         enc = ENC_COAST;
    endcase
    {dir1_o, dir2_o} = enc;
    duty_o = duty_q;
    busy_o = (state_q == RAMPDOWN) || (state_q == DEAD) ||
             (duty_q != tgt_duty_i);
  end

endmodule

// File: rtl/motor_drive_sequencer.sv
// Top level: ramp prescaler, per-channel target registers, command
// decode and e-stop fan-out to the channel state machines.
module motor_drive_sequencer
  import motor_seq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DUTY_W     = 8,
  parameter int RAMP_DIV   = 50000,
  parameter int STEP       = 4,
  parameter int DEAD_TICKS = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
  input  logic                     cmd_dir,
  input  logic [DUTY_W-1:0]        cmd_duty,
  input  logic                     estop,
  output logic [NUM_CH*DUTY_W-1:0] duty_out,
  output logic [NUM_CH-1:0]        dir1_out,
  output logic [NUM_CH-1:0]        dir2_out,
  output logic [NUM_CH-1:0]        busy
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  logic [NUM_CH-1:0][DUTY_W-1:0] tduty_q, tduty_d;
  logic [NUM_CH-1:0]             tdir_q, tdir_d;

  assign cmd_ready = !reset && !estop;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // e-stop wipes every target so channels fall back to IDLE on release
  always_comb begin
    tduty_d = tduty_q;
    tdir_d  = tdir_q;
    if (estop) begin
      tduty_d = '0;
      tdir_d  = '0;
    end else if (cmd_valid && cmd_ready) begin
      tduty_d[cmd_ch] = cmd_duty;
      tdir_d[cmd_ch]  = cmd_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      tduty_q <= '0;
      tdir_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      tduty_q <= tduty_d;
      tdir_q  <= tdir_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    motor_channel_fsm #(
      .DUTY_W     (DUTY_W),
      .STEP       (STEP),
      .DEAD_TICKS (DEAD_TICKS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (tick),
      .estop_i    (estop),
      .tgt_dir_i  (tdir_q[g]),
      .tgt_duty_i (tduty_q[g]),
      .duty_o     (duty_out[g*DUTY_W +: DUTY_W]),
      .dir1_o     (dir1_out[g]),
      .dir2_o     (dir2_out[g]),
      .busy_o     (busy[g])
    );
  end

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Bench for motor_drive_sequencer: directed scenarios plus random
// traffic, all checked against a behavioural channel model.
module tb_motor_drive_sequencer;

  localparam int RD = 4;
  localparam int ST = 4;
  localparam int DT = 2;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_dir, estop;
  logic [1:0]  cmd_ch;
  logic [7:0]  cmd_duty;
  logic        cmd_ready;
  logic [31:0] duty_out;
  logic [3:0]  dir1_out, dir2_out, busy;

  int nvec = 0;
  int nbad = 0;

  motor_drive_sequencer #(
    .NUM_CH(4), .DUTY_W(8), .RAMP_DIV(RD), .STEP(ST), .DEAD_TICKS(DT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_dir(cmd_dir),
    .cmd_duty(cmd_duty), .estop(estop), .duty_out(duty_out),
    .dir1_out(dir1_out), .dir2_out(dir2_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural model: modes and plain integers per channel
  localparam int M_OFF = 0, M_RUN = 1, M_DOWN = 2, M_GAP = 3, M_STOP = 4;
  int m_mode[4], m_duty[4], m_dir[4], m_gap[4];
  int t_duty[4], t_dir[4];
  int m_pre;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_edge();
    bit tk;
    if (reset) begin
      m_pre = 0;
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = M_OFF; m_duty[i] = 0; m_dir[i] = 0;
        m_gap[i] = 0; t_duty[i] = 0; t_dir[i] = 0;
      end
      return;
    end
    tk = (m_pre == RD - 1);
    m_pre = tk ? 0 : m_pre + 1;
    for (int i = 0; i < 4; i++) begin
      if (estop) begin
        m_mode[i] = M_STOP; m_duty[i] = 0;
      end else if (m_mode[i] == M_OFF) begin
        if (t_duty[i] > 0) begin m_mode[i] = M_RUN; m_dir[i] = t_dir[i]; end
      end else if (m_mode[i] == M_RUN) begin
        if (t_dir[i] != m_dir[i]) begin
          if (tk) m_duty[i] -= imin(ST, m_duty[i]);
          m_mode[i] = (m_duty[i] == 0) ? M_GAP : M_DOWN;
          m_gap[i] = 0;
        end else begin
          if (tk && t_duty[i] > m_duty[i]) m_duty[i] += imin(ST, t_duty[i] - m_duty[i]);
          else if (tk) m_duty[i] -= imin(ST, m_duty[i] - t_duty[i]);
          if (t_duty[i] == 0 && m_duty[i] == 0) m_mode[i] = M_OFF;
        end
      end else if (m_mode[i] == M_DOWN) begin
        if (tk) m_duty[i] -= imin(ST, m_duty[i]);
        if (m_duty[i] == 0) begin m_mode[i] = M_GAP; m_gap[i] = 0; end
      end else if (m_mode[i] == M_GAP) begin
        if (tk) m_gap[i]++;
        if (m_gap[i] == DT) begin
          m_gap[i] = 0;
          if (t_duty[i] > 0) begin m_mode[i] = M_RUN; m_dir[i] = t_dir[i]; end
          else m_mode[i] = M_OFF;
        end
      end else begin
        m_mode[i] = M_GAP; m_gap[i] = 0;
      end
    end
    if (estop) begin
      for (int i = 0; i < 4; i++) begin t_duty[i] = 0; t_dir[i] = 0; end
    end else if (cmd_valid) begin
      t_duty[int'(cmd_ch)] = int'(cmd_duty);
      t_dir[int'(cmd_ch)] = int'(cmd_dir);
    end
  endfunction

  function automatic logic [44:0] exp_vec();
    logic [31:0] d;
    logic [3:0] a, b, bz;
    for (int i = 0; i < 4; i++) begin
      d[i*8 +: 8] = 8'(m_duty[i]);
      a[i] = 1'b0; b[i] = 1'b0;
      if (m_mode[i] == M_RUN || m_mode[i] == M_DOWN) begin
        a[i] = (m_dir[i] == 0); b[i] = (m_dir[i] == 1);
      end else if (m_mode[i] == M_STOP) begin
        a[i] = 1'b1; b[i] = 1'b1;
      end
      bz[i] = (m_mode[i] == M_DOWN) || (m_mode[i] == M_GAP) ||
              (m_duty[i] != t_duty[i]);
    end
    return {d, a, b, bz, !reset && !estop};
  endfunction

  function automatic logic [44:0] obs();
    return {duty_out, dir1_out, dir2_out, busy, cmd_ready};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic put_cmd(input logic [1:0] ch, input logic d,
                         input logic [7:0] du);
    cmd_valid = 1'b1; cmd_ch = ch; cmd_dir = d; cmd_duty = du;
  endtask

  task automatic test_reset();
    reset = 1'b1; estop = 1'b0; cmd_valid = 1'b0;
    cmd_ch = '0; cmd_dir = 1'b0; cmd_duty = '0;
    repeat (2) cycle();
    nvec++;
    if (obs() !== 45'd0) begin
      nbad++; $display("FAIL reset_zero got %h want 0", obs());
    end
    reset = 1'b0;
    cycle();
    nvec++;
    if (obs() !== exp_vec()) begin
      nbad++; $display("FAIL reset_release got %h want %h", obs(), exp_vec());
    end
  endtask

  task automatic test_ramp_up();
    logic [7:0] prev;
    int seq[$];
    prev = duty_out[7:0];
    put_cmd(2'd0, 1'b0, 8'd10);
    for (int k = 0; k < 24; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL ramp_up got %h want %h", obs(), exp_vec());
      end
      if (duty_out[7:0] != prev) begin seq.push_back(int'(duty_out[7:0])); prev = duty_out[7:0]; end
    end
    nvec++;
    if (seq.size() != 3 || seq[0] != 4 || seq[1] != 8 || seq[2] != 10) begin
      nbad++; $display("FAIL ramp_seq got %0d steps, last %0d, want 4,8,10", seq.size(), prev);
    end
    nvec++;
    if ({dir1_out[0], dir2_out[0], busy[0]} !== 3'b100) begin
      nbad++; $display("FAIL ramp_dir_busy got %b want 100", {dir1_out[0], dir2_out[0], busy[0]});
    end
    nvec++;
    if (duty_out[31:8] !== 24'd0) begin
      nbad++; $display("FAIL ramp_others got %h want 0", duty_out[31:8]);
    end
  endtask

  task automatic test_reversal();
    logic [7:0] prev;
    int seq[$];
    int coast;
    prev = duty_out[7:0];
    coast = 0;
    put_cmd(2'd0, 1'b1, 8'd6);
    for (int k = 0; k < 40; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL reversal got %h want %h", obs(), exp_vec());
      end
      if (duty_out[7:0] != prev) begin seq.push_back(int'(duty_out[7:0])); prev = duty_out[7:0]; end
      if (!dir1_out[0] && !dir2_out[0]) coast++;
    end
    nvec++;
    if (seq.size() != 5 || seq[0] != 6 || seq[1] != 2 || seq[2] != 0 ||
        seq[3] != 4 || seq[4] != 6) begin
      nbad++; $display("FAIL rev_seq got %0d steps, last %0d, want 6,2,0,4,6", seq.size(), prev);
    end
    nvec++;
    if (coast != DT * RD) begin
      nbad++; $display("FAIL rev_coast got %0d cycles want %0d", coast, DT * RD);
    end
    nvec++;
    if ({dir1_out[0], dir2_out[0]} !== 2'b01) begin
      nbad++; $display("FAIL rev_dir got %b want 01", {dir1_out[0], dir2_out[0]});
    end
  endtask

  task automatic test_stop_idle();
    logic [7:0] prev;
    int seq[$];
    prev = duty_out[15:8];
    for (int ph = 0; ph < 2; ph++) begin
      put_cmd(2'd1, 1'b0, (ph == 0) ? 8'd8 : 8'd0);
      for (int k = 0; k < 16; k++) begin
        cycle(); cmd_valid = 1'b0;
        nvec++;
        if (obs() !== exp_vec()) begin
          nbad++; $display("FAIL stop_idle got %h want %h", obs(), exp_vec());
        end
        if (duty_out[15:8] != prev) begin seq.push_back(int'(duty_out[15:8])); prev = duty_out[15:8]; end
      end
    end
    nvec++;
    if (seq.size() != 4 || seq[0] != 4 || seq[1] != 8 || seq[2] != 4 || seq[3] != 0) begin
      nbad++; $display("FAIL stop_seq got %0d steps want 4,8,4,0", seq.size());
    end
    nvec++;
    if ({dir1_out[1], dir2_out[1], busy[1]} !== 3'b000) begin
      nbad++; $display("FAIL stop_state got %b want 000", {dir1_out[1], dir2_out[1], busy[1]});
    end
  endtask

  task automatic test_estop();
    put_cmd(2'd2, 1'b0, 8'd12);
    for (int k = 0; k < 8; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL estop_pre got %h want %h", obs(), exp_vec());
      end
    end
    estop = 1'b1;
    put_cmd(2'd1, 1'b0, 8'd50);
    cycle();
    nvec++;
    if ({duty_out, dir1_out, dir2_out, cmd_ready} !== {32'd0, 4'hF, 4'hF, 1'b0}) begin
      nbad++; $display("FAIL estop_brake got %h want brake", {duty_out, dir1_out, dir2_out, cmd_ready});
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL estop_hold got %h want %h", obs(), exp_vec());
      end
    end
    estop = 1'b0; cmd_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      cycle();
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL estop_release got %h want %h", obs(), exp_vec());
      end
    end
    nvec++;
    if ({duty_out, dir1_out, dir2_out, busy} !== 44'd0) begin
      nbad++; $display("FAIL estop_idle got %h want 0", {duty_out, dir1_out, dir2_out, busy});
    end
  endtask

  task automatic test_saturation();
    logic [7:0] prev;
    int below;
    bit hit;
    prev = 8'd0; below = -1; hit = 1'b0;
    put_cmd(2'd3, 1'b0, 8'd255);
    for (int k = 0; k < 300 && !hit; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL sat_up got %h want %h", obs(), exp_vec());
      end
      if (duty_out[31:24] == 8'd255) begin hit = 1'b1; below = int'(prev); end
      prev = duty_out[31:24];
    end
    nvec++;
    if (!hit || below != 252) begin
      nbad++; $display("FAIL sat_top got hit=%0d prev=%0d want 252->255", hit, below);
    end
    put_cmd(2'd3, 1'b0, 8'd253);
    for (int k = 0; k < 12; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL sat_down got %h want %h", obs(), exp_vec());
      end
    end
    nvec++;
    if (duty_out[31:24] !== 8'd253 || busy[3] !== 1'b0) begin
      nbad++; $display("FAIL sat_settle got %0d busy %b want 253 0", duty_out[31:24], busy[3]);
    end
    estop = 1'b1;
    put_cmd(2'd3, 1'b0, 8'd10);
    cycle();
    estop = 1'b0; cmd_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycle();
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL sat_estop got %h want %h", obs(), exp_vec());
      end
    end
    nvec++;
    if ({duty_out[31:24], busy[3]} !== 9'd0) begin
      nbad++; $display("FAIL estop_cmd_ignored got %h want 0", {duty_out[31:24], busy[3]});
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int lat;
    hit = 1'b0; lat = -1;
    put_cmd(2'd0, 1'b0, 8'd20);
    for (int k = 0; k < 30 && !hit; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL rmid_ramp got %h want %h", obs(), exp_vec());
      end
      if (duty_out[7:0] == 8'd8) hit = 1'b1;
    end
    nvec++;
    if (!hit) begin
      nbad++; $display("FAIL rmid_wait got %0d want 8", duty_out[7:0]);
    end
    reset = 1'b1;
    cycle();
    nvec++;
    if (obs() !== 45'd0) begin
      nbad++; $display("FAIL rmid_reset got %h want 0", obs());
    end
    reset = 1'b0;
    put_cmd(2'd0, 1'b0, 8'd20);
    for (int k = 1; k <= 12; k++) begin
      cycle(); cmd_valid = 1'b0;
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL rmid_restart got %h want %h", obs(), exp_vec());
      end
      if (lat < 0 && duty_out[7:0] != 8'd0) lat = k;
    end
    nvec++;
    if (lat != RD) begin
      nbad++; $display("FAIL rmid_latency got %0d want %0d", lat, RD);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      int r;
      cmd_valid = ($urandom_range(2) == 0);
      cmd_ch = 2'($urandom_range(3));
      cmd_dir = 1'($urandom_range(1));
      r = int'($urandom_range(3));
      cmd_duty = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : 8'($urandom_range(255));
      if (estop) estop = ($urandom_range(5) != 0);
      else estop = ($urandom_range(79) == 0);
      reset = ($urandom_range(399) == 0);
      cycle();
      nvec++;
      if (obs() !== exp_vec()) begin
        nbad++; $display("FAIL random k=%0d got %h want %h", k, obs(), exp_vec());
      end
    end
    reset = 1'b0; estop = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_stop_idle();
    test_estop();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
Name: motor_drive_sequencer

Overview:
- Sequences the four brushed-motor PWM channels (duty and direction pair) from HPS-issued per-channel commands.
- Applies rate-limited duty ramps, coast dead time on direction reversal, and a global obstacle e-stop driven by the sonar comparator.
- Sits between the HPS Avalon command register and the pwmbrushed channel inputs.

Parameters:
- NUM_CH, 4, number of motor channels.
- DUTY_W, 8, duty width in bits.
- RAMP_DIV, 50000, clk cycles per ramp tick (1 ms at 50 MHz).
- STEP, 4, maximum duty change per ramp tick.
- DEAD_TICKS, 20, ramp ticks of coast between opposite directions.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_ch  in  2  target channel index.
- cmd_dir  in  1  requested direction, 0=fwd, 1=rev.
- cmd_duty  in  DUTY_W  requested duty.
- estop  in  1  obstacle stop, level sensitive.
- duty_out  out  NUM_CH*DUTY_W  per-channel duty, channel i at [i*DUTY_W +: DUTY_W].
- dir1_out  out  NUM_CH  direction1 per channel.
- dir2_out  out  NUM_CH  direction2 per channel.
- busy  out  NUM_CH  channel is not settled (duty differs from target, or channel is in RAMPDOWN/DEAD).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: duty_out=0, dir1_out=0, dir2_out=0 (coast), busy=0, cmd_ready=0 during reset. All targets=0, all channels IDLE, prescaler=0.
- cmd_ready = !reset && !estop.
- Accepted command writes target_dir and target_duty of cmd_ch, visible to that channel's FSM on the next cycle. A later command to the same channel overwrites its target at any time.
- Prescaler: counts 0..RAMP_DIV-1. tick is a one-cycle pulse when count==RAMP_DIV-1, then wraps to 0. tick is shared by all channels.
- Direction encoding: fwd = dir1=1, dir2=0. rev = dir1=0, dir2=1. coast = 0,0. brake = 1,1.
- Channel FSM states: IDLE, DRIVE, RAMPDOWN, DEAD, ESTOP.
- IDLE: coast, duty 0. When target_duty>0, go to DRIVE and latch cur_dir=target_dir.
- DRIVE: outputs cur_dir.
  - On tick, duty moves toward target_duty by min(STEP, |diff|); it never overshoots and saturates exactly at target.
  - If target_dir!=cur_dir, go to RAMPDOWN.
  - If target_duty==0 and duty reaches 0, go to IDLE.
- RAMPDOWN: outputs cur_dir. On tick, duty decrements by min(STEP, duty). When duty==0, go to DEAD with dead counter=0.
- DEAD: coast, duty 0. Dead counter increments on tick. At DEAD_TICKS ticks:
  - if target_duty>0, go to DRIVE with cur_dir=target_dir;
  - else go to IDLE.
  - If target_dir flips back to cur_dir during DEAD, DEAD still completes.
- ESTOP: entered from any state the cycle after estop=1 is sampled.
  - Outputs brake with duty=0 immediately on entry; no ramp.
  - All targets are cleared to 0.
  - Remains in ESTOP while estop=1.
  - On estop=0, go to DEAD (counter=0), which resolves to IDLE because targets are 0.
- Simultaneous cmd_valid and estop: the command is not accepted (cmd_ready=0), and estop wins.
- Reset mid-ramp: outputs return to reset values on the next edge.
- Duty arithmetic uses DUTY_W+1 bits internally. Duty never leaves [0, 2^DUTY_W-1].
- Latency: command to first duty change is at most RAMP_DIV+1 cycles.

Decomposition:
- Package motor_seq_pkg:
  - chan_state_t enum (IDLE, DRIVE, RAMPDOWN, DEAD, ESTOP);
  - DIR_FWD and DIR_REV constants;
  - localparam encodings for coast, fwd, rev, brake.
- Sub-module motor_channel_fsm: one channel's state, duty ramp and dead counter. It is instantiated NUM_CH times.
- The top level holds the prescaler, target registers, the command decoder and e-stop fan-out.

Test Plan:
Bench parameters: RAMP_DIV=4, STEP=4, DEAD_TICKS=2.
- Ramp up: cmd ch0 fwd duty=10 → duty_out0 goes 4, 8, 10 on successive ticks (one tick every 4 cycles); dir1/dir2=1,0; busy0 falls when duty=10; other channels stay 0.
- Reversal: ch0 at 10 fwd, cmd rev duty=6 → duty ramps 6, 2, 0; then coast 0,0 for 2 ticks; then dir=0,1 with duty 4, 6.
- Stop to idle: ch1 at 8, cmd duty=0 → duty 4, 0; then IDLE with coast; busy1=0.
- E-stop: channels 0 and 2 driving, estop=1 → next cycle all duty=0, dir1=dir2=1, cmd_ready=0; a cmd_valid during estop is ignored. Release → coast for 2 ticks, then IDLE with targets 0.
- Saturation and overwrite: cmd ch3 duty=255 then duty=253 mid-ramp → duty never exceeds 255 and settles exactly at 253. A same-cycle cmd_valid with estop=1 → no target change.
- Reset mid-ramp: assert reset while ch0 is at duty 8 → next cycle all outputs 0, coast, and prescaler restarts from 0.
